// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : 8N1 UART transmitter with a one-byte holding buffer
//           (optional even parity bit when UART_TX_PARITY_EN is defined)
// Rev 1.0
// ============================================================================
module uart_tx #(
  parameter int BIT_PERIOD = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] LAST_CNT = 16'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  buf_data;
  logic        buf_full;
  logic        load;
  logic        accept;
  logic        bit_end;
  logic        tx_nxt;
  logic        done_nxt;
  logic        busy_nxt;
`ifdef UART_TX_PARITY_EN
  logic        par, par_nxt;
`endif

  assign tx_ready = !buf_full;
  assign accept   = tx_valid && !buf_full;
  assign bit_end  = (bit_cnt == LAST_CNT);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par;
`endif

    case (state)
      IDLE: begin
        if (buf_full) begin
          load        = 1'b1;
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          // A waiting byte chains straight into the next start bit.
          if (buf_full) begin
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
        bit_idx_nxt = '0;
      end
    endcase

    if (load) begin
      shift_nxt = buf_data;
`ifdef UART_TX_PARITY_EN
      par_nxt   = ^buf_data;
`endif
    end
  end

  // Line outputs are registered from the current state, one clock behind it.
  always_comb begin
    tx_nxt   = 1'b1;
    done_nxt = 1'b0;
    busy_nxt = (state != IDLE);
    case (state)
      IDLE:   tx_nxt = 1'b1;
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = par;
`endif
      STOP: begin
        tx_nxt   = 1'b1;
        done_nxt = bit_end;
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
      tx_busy <= busy_nxt;
      tx_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par     <= par_nxt;
`endif
      if (load) begin
        buf_full <= 1'b0;
      end
      if (accept) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
